// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states and fetch constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/controle_busca_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port,
// IF/ID latch contents and fetch status out.
interface controle_busca_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall;
  logic                  flush;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [DATA_WIDTH-1:0] jump_target;
  logic                  halt_req;
  logic                  resume;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] pc;
  logic                  if_id_valid;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic [DATA_WIDTH-1:0] if_id_pc_plus4;
  logic [1:0]            fetch_state;
  logic                  fetch_fault;

  // Fetch controller side
  modport slave (
    input  stall, flush, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, instruction,
    output pc, if_id_valid, if_id_instr, if_id_pc_plus4, fetch_state,
           fetch_fault
  );

  // Pipeline / memory side driving the controller
  modport master (
    output stall, flush, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, instruction,
    input  pc, if_id_valid, if_id_instr, if_id_pc_plus4, fetch_state,
           fetch_fault
  );
endinterface

// File: rtl/controle_busca_sel_prox_pc.sv
// Next-PC selector: jump > branch > stall-hold > sequential, with
// redirect targets word-aligned.
module sel_prox_pc
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  redirect
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  // Priority mux; pc+4 wraps naturally at the word width
  always_comb begin
    pc_plus4 = pc + DATA_WIDTH'(PC_INC);
    redirect = jump | branch_taken;
    if (jump)              next_pc = jump_target & ALIGN_MASK;
    else if (branch_taken) next_pc = branch_target & ALIGN_MASK;
    else if (stall)        next_pc = pc;
    else                   next_pc = pc_plus4;
  end

endmodule

// File: rtl/controle_busca.sv
// Fetch-stage controller: PC register, BOOT/RUN/HALT FSM and IF/ID latch.
// Optional macro FETCH_BOUND_CHECK_EN: out-of-range fetches raise a sticky
// fetch_fault and halt the stage.
module controle_busca
  import mips_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ROM_ADDR_BITS = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned           BOOT_CYCLES   = 2
) (
  input logic             clk,
  input logic             rst_n,
  controle_busca_if.slave bus
);

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic BOUND_CHECK = 1'b1;
`else
  localparam logic BOUND_CHECK = 1'b0;
`endif

  fetch_state_t          state_q, state_d;
  logic [CNT_W-1:0]      boot_cnt_q, boot_cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  fault_q;
  logic                  out_of_range;
  logic                  bound_hit;

  logic [DATA_WIDTH-1:0] sel_next_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  redirect;

  sel_prox_pc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sel_prox_pc (
    .pc            (pc_q),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .stall         (bus.stall),
    .next_pc       (sel_next_pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect)
  );

  // Any set bit above the ROM byte range means the fetch is out of bounds
  assign out_of_range = |pc_q[DATA_WIDTH-1:ROM_ADDR_BITS+2];
  assign bound_hit    = BOUND_CHECK & out_of_range & (state_q == ST_RUN);

`ifdef FETCH_BOUND_CHECK_EN
  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_q <= 1'b0;
    else if (bound_hit) fault_q <= 1'b1;
  end
`else
  assign fault_q = 1'b0;
`endif

  // Next-state, next-PC and IF/ID contents
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    valid_d    = 1'b0;
    instr_d    = DATA_WIDTH'(NOP_INSTR);
    pc4_d      = '0;

    case (state_q)
      ST_BOOT: begin
        pc_d = RESET_PC;
        if (boot_cnt_q == BOOT_LAST) begin
          boot_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        pc_d = sel_next_pc;
        // Redirect squashes the wrong-path word even under stall; halt and
        // bound faults also bubble rather than hold.
        if (redirect || bus.flush || bus.halt_req || bound_hit) begin
          valid_d = 1'b0;
        end else if (bus.stall) begin
          valid_d = valid_q;
          instr_d = instr_q;
          pc4_d   = pc4_q;
        end else begin
          valid_d = 1'b1;
          instr_d = bus.instruction;
          pc4_d   = pc_plus4;
        end
        if (bus.halt_req || bound_hit) state_d = ST_HALT;
      end

      ST_HALT: begin
        if (bus.resume && !bus.halt_req && !fault_q) state_d = ST_RUN;
      end

      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = '0;
        pc_d       = RESET_PC;
      end
    endcase
  end

  // PC, FSM and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc4_q      <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.fetch_state    = state_q;
  assign bus.fetch_fault    = fault_q;

endmodule
